mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle shift-add multiplier controller for the ARM core's MUL/MULS path.
//  It replaces the combinational multiply in the datapath. The decoder raises
//  start with operands Rn/Rm. The block stalls the core (PC and register-file
//  write held) until the product is ready. It then pulses done for the
//  writeback cycle. Result is the low WIDTH bits of a*b (ARM MUL semantics).
// PARAMETERS
//  WIDTH       32  operand/result width in bits
//  EARLY_TERM  1   1: finish as soon as the remaining multiplier is 0
//                  0: always run WIDTH iterations
// PORTS
//  clk       in   1      system clock, all state on posedge
//  reset     in   1      synchronous, active-low (0 = reset)
//  start     in   1      request a multiply; sampled only in IDLE/DONE
//  flush     in   1      abort in-flight multiply (branch/exception squash)
//  op_a      in   WIDTH  multiplicand, captured on accepted start
//  op_b      in   WIDTH  multiplier, captured on accepted start
//  stall     out  1      hold PC/IF/writeback while a multiply is pending
//  done      out  1      one-cycle pulse; result valid for writeback
//  result    out  WIDTH  product (low WIDTH bits), held until next completion
//  flag_n    out  1      result[WIDTH-1], registered with result
//  flag_z    out  1      result == 0, registered with result
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, result=0, flag_n=0, flag_z=1,
//    done=0. Internal acc/a/b/count are cleared. Reset wins over all inputs.
//  - Registers: acc[WIDTH], a_sh[WIDTH], b_sh[WIDTH],
//    count[$clog2(WIDTH)+1], state {IDLE, RUN, DONE}.
//  - Accept: start && !flush in IDLE or DONE.
//    Effect: acc<=0, a_sh<=op_a, b_sh<=op_b, count<=0, state<=RUN.
//  - RUN, per cycle:
//      if b_sh[0], acc<=acc+a_sh (mod 2^WIDTH);
//      a_sh<=a_sh<<1; b_sh<=b_sh>>1; count<=count+1.
//  - Leave RUN -> DONE when count==WIDTH-1, or when EARLY_TERM and (b_sh>>1)==0.
//    On that edge, result<=final acc (including this cycle's add); n/z update.
//  - DONE lasts exactly one cycle with done=1. Next state is RUN if accepted,
//    else IDLE.
//  - Min RUN cycles = 1 (op_b==0 or 1 with EARLY_TERM).
//    Max RUN cycles = WIDTH.
//  - Latency: start accepted at edge k -> done high in cycle k+1+R,
//    where R = number of RUN cycles.
//  - stall = (start && !flush && state!=RUN) || (state==RUN). It is
//    combinational so the core freezes in the start cycle itself.
//    stall is 0 in the DONE cycle unless a new start is accepted there.
//  - start while RUN: ignored, no effect on operands or count.
//  - flush in RUN: state<=IDLE next edge, no done, result/flags unchanged.
//  - flush with start in the same cycle: flush wins, no accept, stall=0.
//  - flush in DONE: done still high this cycle (already committed); next IDLE.
//  - Overflow beyond WIDTH bits is discarded silently; no carry/overflow flag.
//  - Signed and unsigned products are identical in the low WIDTH bits.
//    No sign handling is needed.
// TESTING
//  1. a=10, b=3, start 1 cycle (k) -> stall high k..k+2, done at k+3,
//     result=30, n=0, z=0.
//  2. EARLY_TERM=1, a=7, b=0 -> 1 RUN cycle, done at k+2, result=0, z=1;
//     b=1 -> result=7 at k+2.
//  3. EARLY_TERM=0, a=0xFFFFFFFF, b=5 -> 32 RUN cycles, done at k+33,
//     result=0xFFFFFFFB, n=1.
//  4. start held high through RUN with a=10, b=3 -> single done at k+3.
//     start still high in the DONE cycle starts a new op: back-to-back,
//     stall stays 1, second done 3 cycles later.
//  5. Complete 6*4 (result=24); then start 9*9 and flush in the 2nd RUN cycle
//     -> IDLE, no done, result stays 24. flush+start together -> no stall,
//     no op.
//  6. reset=0 during RUN of 10*3 -> next edge: done=0, stall=0, result=0,
//     z=1; release and rerun 10*3 -> 30.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller for the MUL/MULS path.
// It holds the core with stall while a product is being built, then pulses
// done for one writeback cycle. result keeps the low WIDTH bits of a*b.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [CW-1:0]    count_q;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] acc_sum;

  // Accept decision, this cycle's partial sum and termination test.
  always_comb begin
    accept    = start && !flush && (state_q != StRun);
    acc_sum   = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
    // Early exit once no multiplier bits remain after this iteration.
    last_iter = (count_q == CW'(WIDTH - 1)) ||
                (EARLY_TERM && (b_sh_q[WIDTH-1:1] == '0));
    // Combinational so the core freezes in the start cycle itself.
    stall     = accept || (state_q == StRun);
  end

  // Controller FSM with datapath and registered done/result/flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      count_q <= '0;
      done    <= 1'b0;
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            acc_q   <= '0;
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            count_q <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (flush) begin
            // Squashed op: no done, previous result and flags stay visible.
            state_q <= StIdle;
          end else begin
            acc_q   <= acc_sum;
            a_sh_q  <= a_sh_q << 1;
            b_sh_q  <= b_sh_q >> 1;
            count_q <= count_q + CW'(1);
            if (last_iter) begin
              state_q <= StDone;
              done    <= 1'b1;
              result  <= acc_sum;
              flag_n  <= acc_sum[WIDTH-1];
              flag_z  <= (acc_sum == '0);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: expected products are queued when an op is
// launched and popped when the selected instance raises done.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [31:0] op_a, op_b;

  logic        stall0, done0, n0, z0;
  logic [31:0] result0;
  logic        stall1, done1, n1, z1;
  logic [31:0] result1;

  bit          sel;
  logic        m_stall, m_done, m_n, m_z;
  logic [31:0] m_result;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(32), .EARLY_TERM(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .stall(stall0), .done(done0),
    .result(result0), .flag_n(n0), .flag_z(z0)
  );

  mul_seq_ctrl #(.WIDTH(32), .EARLY_TERM(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .stall(stall1), .done(done1),
    .result(result1), .flag_n(n1), .flag_z(z1)
  );

  assign m_stall  = sel ? stall1  : stall0;
  assign m_done   = sel ? done1   : done0;
  assign m_result = sel ? result1 : result0;
  assign m_n      = sel ? n1      : n0;
  assign m_z      = sel ? z1      : z0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; stall must already be high in that cycle.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [31:0] p;
    p = a * b;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) exp_q.push_back(p);
    @(negedge clk);
    chk("stall_start", {31'd0, m_stall}, 32'd1);
    tick();
    start = 1'b0;
  endtask

  // Called in cycle k+1; done expected exp_off cycles after the start cycle k.
  task automatic wait_done(input int exp_off, input logic exp_stall);
    int          off;
    bit          got;
    logic [31:0] e;
    off = 1;
    got = 1'b0;
    while (!got && off <= exp_off + 4) begin
      @(negedge clk);
      if (m_done) begin
        got = 1'b1;
      end else begin
        chk("stall_busy", {31'd0, m_stall}, 32'd1);
        tick();
        off++;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", 32'(off), 32'(exp_off));
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result", m_result, e);
      chk("flag_n", {31'd0, m_n}, {31'd0, e[31]});
      chk("flag_z", {31'd0, m_z}, {31'd0, (e == 32'd0)});
      chk("stall_done", {31'd0, m_stall}, {31'd0, exp_stall});
      tick();
      chk("done_pulse", {31'd0, m_done}, 32'd0);
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // Idle observation: no done, no stall, result held.
  task automatic quiet(input int n, input logic [31:0] held);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("quiet_done", {31'd0, m_done}, 32'd0);
      chk("quiet_stall", {31'd0, m_stall}, 32'd0);
      chk("quiet_result", m_result, held);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result0, 32'd0);
    chk("rst_z", {31'd0, z0}, 32'd1);
    chk("rst_n", {31'd0, n0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_stall", {31'd0, stall0}, 32'd0);
    chk("rst_z_full", {31'd0, z1}, 32'd1);
    reset = 1'b1;
    tick();

    // Full-length run without early termination.
    sel = 1'b1;
    do_start(32'hFFFF_FFFF, 32'd5, 1'b1);
    wait_done(33, 1'b0);
    sel = 1'b0;
    repeat (3) tick();

    // Basic multiply: 2 RUN cycles.
    do_start(32'd10, 32'd3, 1'b1);
    wait_done(3, 1'b0);

    // Minimum RUN length with early termination.
    do_start(32'd7, 32'd0, 1'b1);
    wait_done(2, 1'b0);
    do_start(32'd7, 32'd1, 1'b1);
    wait_done(2, 1'b0);

    // start held through RUN: operand changes ignored, restart in DONE cycle.
    op_a  = 32'd10;
    op_b  = 32'd3;
    start = 1'b1;
    exp_q.push_back(32'd30);
    @(negedge clk);
    chk("stall_start_held", {31'd0, m_stall}, 32'd1);
    tick();
    op_a = 32'd2;
    op_b = 32'd3;
    exp_q.push_back(32'd6);
    wait_done(3, 1'b1);
    start = 1'b0;
    wait_done(3, 1'b0);

    // Flush in the second RUN cycle, then flush together with start.
    do_start(32'd6, 32'd4, 1'b1);
    wait_done(4, 1'b0);
    do_start(32'd9, 32'd9, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    quiet(3, 32'd24);
    op_a  = 32'd5;
    op_b  = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("stall_flush_start", {31'd0, m_stall}, 32'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    quiet(3, 32'd24);

    // Reset during RUN, then rerun.
    do_start(32'd10, 32'd3, 1'b0);
    reset = 1'b0;
    tick();
    chk("mid_rst_done", {31'd0, m_done}, 32'd0);
    chk("mid_rst_stall", {31'd0, m_stall}, 32'd0);
    chk("mid_rst_result", m_result, 32'd0);
    chk("mid_rst_z", {31'd0, m_z}, 32'd1);
    reset = 1'b1;
    tick();
    do_start(32'd10, 32'd3, 1'b1);
    wait_done(3, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
